// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   state_t          - loader FSM states
//   HDR_BYTES        - number of header (word count) bytes before the payload
//   bytes_per_word() - payload bytes packed into one instruction word
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (used by imem_loader).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHK,
    DONE_ST
  } state_t;

  localparam int unsigned HDR_BYTES = 2;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: collects bytes little-endian into one instruction word.
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   clear        - restart packing (new load)
//   byte_en      - byte_data is consumed this cycle
//   byte_data    - incoming byte
//   word         - packed word (first byte of the word in [7:0])
//   byte_last    - the next consumed byte completes the word
//   word_valid   - word is complete (one cycle after the final byte)
module imem_byte_packer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTES_PER_WORD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  byte_last,
  output logic                  word_valid
);

  localparam int unsigned CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [CW-1:0] byte_cnt;

  assign byte_last = (byte_cnt == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && byte_last;
      if (byte_en) begin
        // Shift in from the top so the first byte ends up in [7:0].
        word     <= {byte_data, word[DATA_WIDTH-1:8]};
        byte_cnt <= byte_last ? '0 : byte_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads an instruction memory from a byte stream.
// Stream: 16-bit little-endian word count N, then N words of 4 bytes each
// (little-endian), then - with IMEM_LOADER_CHECKSUM_EN defined - one byte
// equal to the XOR of all payload bytes.
// Ports:
//   clk, rst           - rising-edge clock, synchronous active-high reset
//   start              - pulse to begin a load (from IDLE or DONE_ST)
//   rx_data/rx_valid   - incoming byte stream; rx_ready = byte accepted
//   mem_we/mem_addr/mem_wdata - instruction-memory write port (byte address)
//   cpu_hold           - keeps the CPU in reset while loading
//   done, error        - sticky completion / abort flags
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_SIZE      = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);

  state_t state, state_nxt;

  logic [7:0]            len_lo;
  logic [15:0]           word_cnt;
  logic [15:0]           word_idx;
  logic [15:0]           idx_next;
  logic [15:0]           hdr_n;
  logic                  load_start;
  logic                  set_done;
  logic                  set_error;
  logic                  accept;
  logic [DATA_WIDTH-1:0] word;
  logic                  byte_last;
  logic                  word_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign accept   = rx_valid && rx_ready;
  assign hdr_n    = {rx_data, len_lo};
  assign idx_next = word_idx + 16'd1;

  imem_byte_packer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTES_PER_WORD(BPW)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .byte_en   ((state == DATA) && rx_valid),
    .byte_data (rx_data),
    .word      (word),
    .byte_last (byte_last),
    .word_valid(word_valid)
  );

  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    set_done   = 1'b0;
    set_error  = 1'b0;
    rx_ready   = 1'b0;
    cpu_hold   = 1'b1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        if (start) begin
          state_nxt  = LEN_LO;
          load_start = 1'b1;
        end
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (hdr_n == 16'd0) begin
            state_nxt = DONE_ST;
            set_done  = 1'b1;
          end else if (32'(hdr_n) > 32'(MEM_SIZE)) begin
            state_nxt = DONE_ST;
            set_error = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_last) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = word_valid;
        mem_addr  = ADDRESS_WIDTH'({word_idx, 2'b00});
        mem_wdata = word;
        if (idx_next == word_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE_ST;
          set_done  = 1'b1;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          state_nxt = DONE_ST;
          if (rx_data == csum) set_done  = 1'b1;
          else                 set_error = 1'b1;
        end
      end
`endif
      DONE_ST: begin
        cpu_hold = 1'b0;
        if (start) begin
          state_nxt  = LEN_LO;
          load_start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_lo   <= '0;
      word_cnt <= '0;
      word_idx <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (load_start) begin
        word_idx <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (state == LEN_LO && accept) len_lo   <= rx_data;
      if (state == LEN_HI && accept) word_cnt <= hdr_n;
      if (state == WRITE)            word_idx <= idx_next;
      if (set_done)                  done     <= 1'b1;
      if (set_error)                 error    <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == DATA && accept)   csum     <= csum ^ rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader.
// Expected writes and outcomes come from a stream-level model; a monitor
// process pops expected writes whenever mem_we is seen.
// Honours IMEM_LOADER_CHECKSUM_EN when defined for the build.
module tb_imem_loader;

  localparam int unsigned MEM_SIZE = 37;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(32),
    .MEM_SIZE     (MEM_SIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [7:0] bytes_t[$];

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  writes_seen = 0;
  int  last_we_cyc = -1;
  int  hold_fall_cyc = -1;
  int  done_rise_cyc = -1;
  bit  exp_done;
  bit  exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] payload_xor(input bytes_t s);
    logic [7:0] x = 8'h00;
    for (int i = 2; i < s.size(); i++) x ^= s[i];
    return x;
  endfunction

  // Stream-level reference: header -> outcome, payload -> list of writes.
  task automatic model(input bytes_t s);
    int unsigned n;
    n = 32'({s[1], s[0]});
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0) begin
      exp_done = 1'b1;
    end else if (n > MEM_SIZE) begin
      exp_err = 1'b1;
    end else begin
      for (int unsigned i = 0; i < n; i++) begin
        wr_t w;
        w.addr = 32'(4 * i);
        w.data = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
        exp_q.push_back(w);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      begin
        logic [7:0] x = 8'h00;
        for (int unsigned i = 0; i < 4 * n; i++) x ^= s[2+i];
        if (s[2+4*n] == x) exp_done = 1'b1;
        else               exp_err  = 1'b1;
      end
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic make_random(input int n, output bytes_t s);
    s = {};
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(0, 255)));
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(payload_xor(s));
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Random idle gaps with rx_valid low, then hold the byte until accepted.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    bit got = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    acc_cyc  = -1;
    for (int t = 0; t < 100 && !got; t++) begin
      if (rx_ready) begin
        @(posedge clk);
        #1;
        got     = 1'b1;
        acc_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("rx_accept", got, 1);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    bit fin = 1'b0;
    for (int t = 0; t < 600 && !fin; t++) begin
      @(negedge clk);
      if (!cpu_hold) fin = 1'b1;
    end
    check({tag, "_finish"}, fin, 1);
  endtask

  task automatic run_load(input bytes_t s, input string tag);
    int acc;
    int hdr_cyc = -1;
    int unsigned n;
    n = 32'({s[1], s[0]});
    model(s);
    done_rise_cyc = -1;
    hold_fall_cyc = -1;
    pulse_start();
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], acc);
      if (i == 1) hdr_cyc = acc;
    end
    idle_bus();
    wait_finish(tag);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    if (n == 0)
      check({tag, "_zero_len_latency"},
            (done_rise_cyc >= hdr_cyc) && (done_rise_cyc - hdr_cyc <= 3), 1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (n > 0 && n <= MEM_SIZE)
      check({tag, "_hold_fall"}, hold_fall_cyc, last_we_cyc + 1);
`endif
  endtask

  initial begin
    bytes_t s;
    int     acc;
    int     base;
    bit     prev_hold = 1'b0;
    bit     prev_done = 1'b0;

    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (mem_we) begin
          writes_seen++;
          last_we_cyc = cyc;
          check("we_with_hold", cpu_hold, 1);
          check("we_without_ready", rx_ready, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_write", mem_we, 0);
          end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("write_addr", mem_addr, w.addr);
            check("write_data", mem_wdata, w.data);
          end
        end
        if (prev_hold && !cpu_hold) hold_fall_cyc = cyc;
        if (!prev_done && done)     done_rise_cyc = cyc;
        prev_hold = cpu_hold;
        prev_done = done;
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_rx_ready", rx_ready, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_cpu_hold", cpu_hold, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word 0x00A00513 at address 0.
    s = {8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(payload_xor(s));
`endif
    run_load(s, "one_word");

    s = {8'h00, 8'h00};
    run_load(s, "zero_len");

    s = {8'h26, 8'h00};
    run_load(s, "too_long");

    make_random(MEM_SIZE, s);
    run_load(s, "max_len");

    make_random(3, s);
    run_load(s, "three_words");

    for (int k = 0; k < 5; k++) begin
      make_random($urandom_range(1, 6), s);
      run_load(s, $sformatf("rand%0d", k));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    s = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_load(s, "chk_good");
    s = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_load(s, "chk_bad");
`endif

    // Reset mid-load: two of three words written, third word half-received.
    make_random(3, s);
    model(s);
    void'(exp_q.pop_back());
    base = writes_seen;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(s[i], acc);
    idle_bus();
    begin
      bit two = 1'b0;
      for (int t = 0; t < 100 && !two; t++) begin
        @(negedge clk);
        if (writes_seen - base >= 2) two = 1'b1;
      end
      check("rst_two_writes", writes_seen - base, 2);
    end
    send_byte(s[10], acc);
    send_byte(s[11], acc);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_cpu_hold", cpu_hold, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    rst = 1'b0;
    // Remaining bytes of the aborted word arrive after reset and must be ignored.
    for (int i = 12; i < s.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
      check("midrst_idle_ready", rx_ready, 0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_third_write", writes_seen - base, 2);
    check("midrst_pending", exp_q.size(), 0);
    check("midrst_still_idle", cpu_hold, 0);

    // Loader must still work after the abort.
    make_random(2, s);
    run_load(s, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
